// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed, checksummed byte stream and writes
// it into instruction memory, one instruction per byte. The processor is held
// in reset until a complete image has been received and its checksum verified.
module prog_loader #(
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0,
    parameter int TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [7:0]        in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              cpu_rst_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int                IW       = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0]     IDLE_MAX = IW'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q;
    logic [7:0]        rem_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        sum_q;
    logic [IW-1:0]     idle_q;
    logic              in_ready_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              cpu_rst_q;
    logic              done_q;
    logic              err_q;

    // in_ready is registered, so an accept depends only on the sampled valid
    logic       accept;
    logic [7:0] sum_d;
    logic       timeout_hit;

    assign accept      = in_valid_i && in_ready_q;
    assign sum_d       = sum_q + in_data_i;
    // idle_q counts completed idle cycles; the TIMEOUT-th idle edge aborts
    assign timeout_hit = (idle_q == IDLE_MAX);

    // Loader FSM with all outputs registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            addr_q      <= BASE;
            sum_q       <= '0;
            idle_q      <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE;
            mem_wdata_q <= '0;
            cpu_rst_q   <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // write strobe is a single-cycle pulse per accepted data byte
            mem_we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_i) begin
                        state_q    <= S_LEN;
                        in_ready_q <= 1'b1;
                        cpu_rst_q  <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        idle_q     <= '0;
                    end
                end
                S_LEN, S_DATA, S_CSUM: begin
                    if (accept) begin
                        idle_q <= '0;
                        case (state_q)
                            S_LEN: begin
                                if (in_data_i == 8'd0) begin
                                    state_q    <= S_ERR;
                                    in_ready_q <= 1'b0;
                                    err_q      <= 1'b1;
                                end else begin
                                    state_q <= S_DATA;
                                    rem_q   <= in_data_i;
                                    addr_q  <= BASE;
                                    sum_q   <= '0;
                                end
                            end
                            S_DATA: begin
                                mem_we_q    <= 1'b1;
                                mem_addr_q  <= addr_q;
                                mem_wdata_q <= in_data_i;
                                addr_q      <= addr_q + 1'b1;
                                sum_q       <= sum_d;
                                rem_q       <= rem_q - 8'd1;
                                if (rem_q == 8'd1) state_q <= S_CSUM;
                            end
                            default: begin
                                // checksum byte: image valid iff total sum wraps to zero
                                in_ready_q <= 1'b0;
                                if (sum_d == 8'd0) begin
                                    state_q   <= S_DONE;
                                    done_q    <= 1'b1;
                                    cpu_rst_q <= 1'b0;
                                end else begin
                                    state_q <= S_ERR;
                                    err_q   <= 1'b1;
                                end
                            end
                        endcase
                    end else if (timeout_hit) begin
                        state_q    <= S_ERR;
                        in_ready_q <= 1'b0;
                        err_q      <= 1'b1;
                    end else begin
                        idle_q <= idle_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    cpu_rst_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign cpu_rst_o   = cpu_rst_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader that fills the instruction memory read by the processor's program counter. It accepts a length-prefixed, checksummed byte stream over a valid/ready handshake and writes each 8-bit instruction word to consecutive memory addresses. It holds the processor in reset while loading and releases it only after a verified image. It is the writer side of the instruction bus the processor's fetch path consumes.

## Interface
- ADDR_W, 16, instruction memory address width (matches the 16-bit pc)
- BASE_ADDR, 0, address of the first instruction written
- TIMEOUT, 1023, max idle cycles between bytes before abort (≥1)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR
- in_data  in  8  stream byte
- in_valid  in  1  in_data is valid
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction memory write strobe, one cycle per instruction
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  8  instruction word written
- cpu_rst  out  1  holds the processor in reset (active-high)
- done  out  1  level; image loaded and verified
- err  out  1  level; load aborted (bad length, bad checksum, timeout)

## Operation
- Stream format: LEN byte N (1..255), then N instruction bytes, then CSUM byte. The image is valid iff (sum of the N instruction bytes + CSUM) mod 256 == 0.
- Transfer: a byte is accepted on a rising clk edge when in_valid && in_ready. in_valid may gap arbitrarily. in_ready does not depend on in_valid.
- FSM states: IDLE, LEN, DATA, CSUM, DONE, ERR.
  - IDLE: in_ready=0, cpu_rst=1. start → LEN.
  - LEN: in_ready=1. Accept N. N==0 → ERR. Otherwise load remaining count=N, addr=BASE_ADDR, sum=0, then → DATA.
  - DATA: in_ready=1. Each accepted byte is written to addr. addr increments, sum += byte (8-bit wrap), remaining decrements. The last byte → CSUM.
  - CSUM: in_ready=1. Accept the checksum byte. (sum+byte)[7:0]==0 → DONE, otherwise → ERR.
  - DONE: done=1, cpu_rst=0, in_ready=0. start → LEN, with cpu_rst=1 and done=0 again.
  - ERR: err=1, cpu_rst=1, in_ready=0. start → LEN, with err cleared.
- start while in LEN, DATA or CSUM is ignored.
- Timeout: an idle counter runs in LEN, DATA and CSUM. It clears on every accepted byte and on entering LEN. When it reaches TIMEOUT with no accept → ERR.
- Address arithmetic: ADDR_W-bit, wraps modulo 2^ADDR_W. No overflow is flagged.
- Memory contents already written before an ERR are not rolled back. cpu_rst staying at 1 is the sole protection.
- All outputs are registered.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_rst=1, done=0, err=0, FSM=IDLE, counters=0.
- rst asserted at any point, including mid-load, forces the reset values immediately (asynchronously). Any pending write is dropped.
- start is sampled at edge T. State is LEN and in_ready=1 from T+1.
- Data byte accepted at edge T: mem_we=1 with that byte's mem_addr/mem_wdata during cycle T+1 only. mem_we is never high for two cycles per byte. Back-to-back accepts produce back-to-back write strobes.
- LEN or CSUM accepted at edge T: done or err is visible from T+1, and in_ready=0 from T+1. cpu_rst falls at T+1 on success.
- Timeout: with no accept for TIMEOUT consecutive cycles in a receive state, err=1 on the next cycle.
- Throughput: one byte per clock. A full load takes N+2 accepting cycles.

## Test plan
- Reset: assert rst mid-cycle → immediately cpu_rst=1, in_ready=0, mem_we=0, done=0, err=0, mem_addr=0.
- Good load: start, then bytes 0x03, 0x45, 0xC7, 0x12, 0xE2 at full rate → writes addr0=0x45, addr1=0xC7, addr2=0x12, each strobe one cycle after accept. done=1 and cpu_rst=0 the cycle after 0xE2 is accepted.
- Bad checksum: same stream with CSUM 0x00 → three writes occur, then err=1, cpu_rst=1, done=0, in_ready=0.
- Zero length: start, then 0x00 → err=1 next cycle, no mem_we. A subsequent start clears err and re-enters LEN.
- Backpressure and timeout (TIMEOUT=8): insert 3-cycle gaps between bytes → load succeeds. Then stall after LEN for 8 cycles → err=1.
- Reset mid-load: rst during DATA after 2 of 4 bytes → outputs return to reset values, no further writes. A fresh start plus a full stream loads correctly from BASE_ADDR.
